regfile_sb: RTL and testbench

Architectural register file with an integrated pending-write scoreboard. It is the receiving end of the write-back stage's register-write interface: it accepts the writes that stage commits and serves operand reads to decode, with same-cycle write-back bypass. It also keeps a per-register count of in-flight writers so hazard logic can stall decode when a source register still has an outstanding producer.

---
 rtl/rv32i_types.sv | 15 +
 rtl/sb_counter.sv | 46 ++++
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types and the pending-write scoreboard constants.
package rv32i_types;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned SB_CNT_W = 2;

  typedef logic [XLEN-1:0]     rv32i_word;
  typedef logic [REG_AW-1:0]   rv32i_reg;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_MAX_C = 2'd3;

endpackage

// File: rtl/sb_counter.sv
// In-flight writer counter for one architectural register.
module sb_counter
  import rv32i_types::*;
#(
  parameter sb_cnt_t MAX = SB_MAX_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [1:0] dec,
  output sb_cnt_t    cnt,
  output logic       full,
  output logic       err
);

  // Four signed bits cover every outcome of cnt + inc - dec (-3..4).
  logic signed [3:0] sum_c;
  sb_cnt_t           cnt_nxt;

  // Next count: clamp underflow to zero, hold on overflow; both flag err.
  always_comb begin
    cnt_nxt = cnt;
    err     = 1'b0;
    sum_c   = $signed({2'b00, cnt}) + $signed({3'b000, inc}) - $signed({2'b00, dec});
    if (sum_c < 4'sd0) begin
      cnt_nxt = '0;
      err     = 1'b1;
    end else if (sum_c > $signed({2'b00, MAX})) begin
      err     = 1'b1;
    end else begin
      cnt_nxt = sum_c[1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign full = (cnt == MAX);

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with write-back bypass and per-register
// in-flight writer scoreboard for decode hazard detection.
module regfile_sb
  import rv32i_types::*;
#(
  parameter int unsigned SB_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_regfile_load,
  input  rv32i_reg        WB_regfile_rd,
  input  rv32i_word       WB_regfile_data,
  input  rv32i_reg        ID_rs1,
  input  rv32i_reg        ID_rs2,
  output rv32i_word       ID_rs1_data,
  output rv32i_word       ID_rs2_data,
  output logic            ID_rs1_busy,
  output logic            ID_rs2_busy,
  input  logic            issue_valid,
  input  rv32i_reg        issue_rd,
  input  logic            issue_writes,
  output logic            issue_full,
  input  logic [1:0]      squash_valid,
  input  logic [1:0][4:0] squash_rd,
  output logic            sb_err
);

  localparam sb_cnt_t MAX_CNT = sb_cnt_t'(SB_MAX);

  rv32i_word            rf [NUM_REGS];
  sb_cnt_t              cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  full_v;
  logic [NUM_REGS-1:0]  err_v;
  logic                 hit1_c;
  logic                 hit2_c;

  // x0 has no counter: never busy, never full, never errs.
  assign cnt[0]    = '0;
  assign full_v[0] = 1'b0;
  assign err_v[0]  = 1'b0;

  // Storage: x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf[5'(i)] <= '0;
      end
    end else if (WB_regfile_load && (WB_regfile_rd != '0)) begin
      rf[WB_regfile_rd] <= WB_regfile_data;
    end
  end

  // One counter per writable register; retire and squashes all decrement.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic       inc;
    logic [1:0] dec;

    assign inc = issue_valid && issue_writes && (issue_rd == rv32i_reg'(r)) && !issue_full;
    assign dec = 2'(WB_regfile_load && (WB_regfile_rd == rv32i_reg'(r)))
               + 2'(squash_valid[0] && (squash_rd[0] == rv32i_reg'(r)))
               + 2'(squash_valid[1] && (squash_rd[1] == rv32i_reg'(r)));

    sb_counter #(
      .MAX (MAX_CNT)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .dec  (dec),
      .cnt  (cnt[r]),
      .full (full_v[r]),
      .err  (err_v[r])
    );
  end

  assign issue_full = full_v[issue_rd] && (issue_rd != '0);

  // Operand reads with same-cycle write-back bypass and retire-aware busy.
  always_comb begin
    ID_rs1_data = rf[ID_rs1];
    ID_rs2_data = rf[ID_rs2];
    hit1_c      = WB_regfile_load && (WB_regfile_rd == ID_rs1);
    hit2_c      = WB_regfile_load && (WB_regfile_rd == ID_rs2);
    if (ID_rs1 == '0) begin
      ID_rs1_data = '0;
    end else if (hit1_c) begin
      ID_rs1_data = WB_regfile_data;
    end
    if (ID_rs2 == '0) begin
      ID_rs2_data = '0;
    end else if (hit2_c) begin
      ID_rs2_data = WB_regfile_data;
    end
    // A retire on a register with no count leaves nothing outstanding.
    ID_rs1_busy = cnt[ID_rs1] > sb_cnt_t'(hit1_c);
    ID_rs2_busy = cnt[ID_rs2] > sb_cnt_t'(hit2_c);
  end

  // Sticky scoreboard error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|err_v) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expectations, monitor checks.
module tb_regfile_sb;
  import rv32i_types::*;

  logic            clk;
  logic            rst;
  logic            WB_regfile_load;
  rv32i_reg        WB_regfile_rd;
  rv32i_word       WB_regfile_data;
  rv32i_reg        ID_rs1;
  rv32i_reg        ID_rs2;
  rv32i_word       ID_rs1_data;
  rv32i_word       ID_rs2_data;
  logic            ID_rs1_busy;
  logic            ID_rs2_busy;
  logic            issue_valid;
  rv32i_reg        issue_rd;
  logic            issue_writes;
  logic            issue_full;
  logic [1:0]      squash_valid;
  logic [1:0][4:0] squash_rd;
  logic            sb_err;

  regfile_sb #(.SB_MAX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .WB_regfile_load (WB_regfile_load),
    .WB_regfile_rd   (WB_regfile_rd),
    .WB_regfile_data (WB_regfile_data),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_rs1_data     (ID_rs1_data),
    .ID_rs2_data     (ID_rs2_data),
    .ID_rs1_busy     (ID_rs1_busy),
    .ID_rs2_busy     (ID_rs2_busy),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_writes    (issue_writes),
    .issue_full      (issue_full),
    .squash_valid    (squash_valid),
    .squash_rd       (squash_rd),
    .sb_err          (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        full;
    logic        err;
    logic        chk_b1;
  } exp_t;

  // Expectation FIFO: written only by stimulus, read only by the monitor.
  exp_t        exp_mem  [256];
  string       name_mem [256];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic push(input string nm, input logic [31:0] d1, input logic b1,
                      input logic [31:0] d2, input logic b2, input logic full,
                      input logic err, input logic chk_b1);
    exp_t e;
    e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2;
    e.full = full; e.err = err; e.chk_b1 = chk_b1;
    exp_mem[wr_idx[7:0]]  = e;
    name_mem[wr_idx[7:0]] = nm;
    wr_idx++;
  endtask

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h at %0t", nm, fld, act, expv, $time);
    end
  endtask

  // Monitor: on each falling edge, check every outstanding expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (rd_idx != wr_idx) begin
        e  = exp_mem[rd_idx[7:0]];
        nm = name_mem[rd_idx[7:0]];
        cmp(nm, "rs1_data", ID_rs1_data, e.d1);
        if (e.chk_b1) cmp(nm, "rs1_busy", 32'(ID_rs1_busy), 32'(e.b1));
        cmp(nm, "rs2_data", ID_rs2_data, e.d2);
        cmp(nm, "rs2_busy", 32'(ID_rs2_busy), 32'(e.b2));
        cmp(nm, "issue_full", 32'(issue_full), 32'(e.full));
        cmp(nm, "sb_err", 32'(sb_err), 32'(e.err));
        rd_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB_regfile_load = 1'b0;
    WB_regfile_rd   = '0;
    WB_regfile_data = '0;
    ID_rs1          = '0;
    ID_rs2          = '0;
    issue_valid     = 1'b0;
    issue_rd        = '0;
    issue_writes    = 1'b0;
    squash_valid    = 2'b00;
    squash_rd       = '0;
  endtask

  task automatic issue(input rv32i_reg rd);
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = rd;
  endtask

  task automatic commit(input rv32i_reg rd, input rv32i_word d);
    WB_regfile_load = 1'b1;
    WB_regfile_rd   = rd;
    WB_regfile_data = d;
  endtask

  // Directed stimulus; each cycle: drive inputs, queue expectation, advance.
  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      idle(); ID_rs1 = 5'(i); ID_rs2 = 5'(31 - i);
      push("rst_sweep", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end

    idle(); issue(5'd5); ID_rs1 = 5'd5;
    push("byp_issue", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    idle(); commit(5'd5, 32'hDEAD_BEEF); ID_rs1 = 5'd5;
    push("byp_same", 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    idle(); ID_rs1 = 5'd5;
    push("byp_next", 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    idle(); commit(5'd0, 32'h1234_5678); issue(5'd0);
    push("x0_wr", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    push("x0_rd", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    for (int k = 0; k < 3; k++) begin
      idle(); issue(5'd7); ID_rs1 = 5'd7;
      push("sb_issue", 32'h0, (k > 0), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end
    idle(); issue(5'd7); ID_rs1 = 5'd7;
    push("sb_full", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    idle(); issue_rd = 5'd7; ID_rs1 = 5'd7;
    push("sb_hold", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    for (int j = 1; j <= 3; j++) begin
      idle(); commit(5'd7, 32'h7000_0000 + 32'(j)); ID_rs1 = 5'd7;
      push("sb_retire", 32'h7000_0000 + 32'(j), (j < 3), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end
    idle(); issue_rd = 5'd7; ID_rs1 = 5'd7;
    push("sb_drained", 32'h7000_0003, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    for (int k = 0; k < 2; k++) begin
      idle(); issue(5'd9); ID_rs2 = 5'd9;
      push("sq_issue", 32'h0, 1'b0, 32'h0, (k == 1), 1'b0, 1'b0, 1'b1); tick();
    end
    idle(); squash_valid = 2'b11; squash_rd = {5'd9, 5'd9}; ID_rs2 = 5'd9;
    push("sq_cycle", 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    idle(); issue_rd = 5'd9; ID_rs2 = 5'd9;
    push("sq_after", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    idle(); commit(5'd3, 32'h3333_3333); ID_rs1 = 5'd3;
    push("uf_cycle", 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle(); issue_rd = 5'd3; ID_rs1 = 5'd3;
    push("uf_after", 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    idle(); issue(5'd11); ID_rs1 = 5'd11;
    push("uf_sticky", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    idle(); ID_rs1 = 5'd11; ID_rs2 = 5'd3;
    push("pre_rst", 32'h0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1); tick();

    rst = 1'b1; idle(); tick(); rst = 1'b0;
    idle(); ID_rs1 = 5'd11; ID_rs2 = 5'd3; issue_rd = 5'd7;
    push("post_rst", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    idle(); ID_rs1 = 5'd5; ID_rs2 = 5'd7;
    push("post_rst2", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
